// File: rtl/menu_pkg.sv
// Shared types, FSM states, default palette and width helpers for the menu page renderer.
package menu_pkg;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} page_state_e;

    localparam rgb444_t DEFAULT_PAL [4] = '{12'h000, 12'hF00, 12'h00F, 12'h0F0};

    function automatic int page_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_w(input int w, input int h);
        return (w * h < 2) ? 1 : $clog2(w * h);
    endfunction

    // Entries beyond the four defined colours come up black.
    function automatic rgb444_t pal_default(input int idx);
        logic [1:0] sel;
        sel = idx[1:0];
        return (idx < 4) ? DEFAULT_PAL[sel] : 12'h000;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with async active-low clear; aligns flags with ROM read data.
module pipe_delay
    import menu_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) stage_q <= '0;
        else           stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/menu_page_renderer.sv
// Menu bitmap renderer: ROM address generation, palette lookup and frame-aligned page switching.
// Optional highlight band inversion is enabled by defining MENU_HIGHLIGHT_EN.
module menu_page_renderer
    import menu_pkg::*;
#(
    parameter int WIDTH       = 512,
    parameter int HEIGHT      = 384,
    parameter int NUM_PAGES   = 4,
    parameter int BPP         = 2,
    parameter int ROM_LATENCY = 1,
    parameter int ITEM_H      = 64,
    localparam int PAGE_W     = page_w(NUM_PAGES),
    localparam int ADDR_W     = addr_w(WIDTH, HEIGHT)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [12:0]       hcount,
    input  logic [12:0]       vcount,
    input  logic              page_req_valid,
    input  logic [PAGE_W-1:0] page_req_id,
    output logic              page_req_ready,
    output logic              page_ack,
    output logic              page_err,
    output logic [PAGE_W-1:0] active_page,
    input  logic              pal_we,
    input  logic [BPP-1:0]    pal_addr,
    input  logic [11:0]       pal_data,
`ifdef MENU_HIGHLIGHT_EN
    input  logic [7:0]        highlight_item,
    input  logic              highlight_on,
`endif
    output logic [PAGE_W-1:0] rom_page,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BPP-1:0]    rom_data,
    output logic [11:0]       pixel_out
);

    localparam int               PAL_N    = 2 ** BPP;
    localparam int               WLOG     = $clog2(WIDTH);
    localparam logic [12:0]      WIDTH_C  = 13'(WIDTH);
    localparam logic [12:0]      HEIGHT_C = 13'(HEIGHT);
    localparam logic [12:0]      ITEM_H_C = 13'(ITEM_H);
    localparam logic [PAGE_W:0]  NPAGE_C  = (PAGE_W + 1)'(NUM_PAGES);

    page_state_e       state_q, state_d;
    logic [PAGE_W-1:0] req_id_q, req_id_d;
    logic [PAGE_W-1:0] active_page_q, active_page_d;
    logic              page_err_q, page_err_d;
    logic              frame_start_q, frame_start_d;
    rgb444_t           pixel_q, pixel_d;
    rgb444_t           pal_q [PAL_N];
    rgb444_t           pal_d [PAL_N];

    logic        in_bounds, band;
    logic [12:0] band_row, hl_sel;
    logic        hl_en;
    logic [1:0]  tag_dly;
    rgb444_t     lut_val;

    // WIDTH is a power of two, so the row multiply is a shift.
    assign rom_addr  = ADDR_W'(hcount) + (ADDR_W'(vcount) << WLOG);
    assign in_bounds = (hcount < WIDTH_C) && (vcount < HEIGHT_C);
    assign band_row  = vcount / ITEM_H_C;

`ifdef MENU_HIGHLIGHT_EN
    assign hl_sel = {5'd0, highlight_item};
    assign hl_en  = highlight_on;
`else
    assign hl_sel = '0;
    assign hl_en  = 1'b0;
`endif

    assign band = in_bounds && hl_en && (band_row == hl_sel);

    pipe_delay #(.W(2), .DEPTH(ROM_LATENCY)) u_tag_dly (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .din      ({band, in_bounds}),
        .dout     (tag_dly)
    );

    // Lookup reads the pre-write palette; a same-cycle write shows up one cycle later.
    assign lut_val = pal_q[rom_data];

    always_comb begin
        pixel_d = '0;
        if (tag_dly[0]) pixel_d = tag_dly[1] ? ~lut_val : lut_val;
        for (int i = 0; i < PAL_N; i++) pal_d[i] = pal_q[i];
        if (pal_we) pal_d[pal_addr] = pal_data;
    end

    assign frame_start_d = (hcount == 13'd0) && (vcount == 13'd0);

    always_comb begin
        state_d        = state_q;
        req_id_d       = req_id_q;
        active_page_d  = active_page_q;
        page_err_d     = 1'b0;
        page_req_ready = 1'b0;
        page_ack       = 1'b0;
        case (state_q)
            IDLE: begin
                page_req_ready = 1'b1;
                if (page_req_valid) begin
                    if ({1'b0, page_req_id} >= NPAGE_C) begin
                        page_err_d = 1'b1;
                    end else begin
                        req_id_d = page_req_id;
                        state_d  = PENDING;
                    end
                end
            end
            PENDING: if (frame_start_q) state_d = COMMIT;
            COMMIT: begin
                active_page_d = req_id_q;
                page_ack      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= IDLE;
            req_id_q      <= '0;
            active_page_q <= '0;
            page_err_q    <= 1'b0;
            frame_start_q <= 1'b0;
            pixel_q       <= '0;
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_default(i);
        end else begin
            state_q       <= state_d;
            req_id_q      <= req_id_d;
            active_page_q <= active_page_d;
            page_err_q    <= page_err_d;
            frame_start_q <= frame_start_d;
            pixel_q       <= pixel_d;
            pal_q         <= pal_d;
        end
    end

    assign page_err    = page_err_q;
    assign active_page = active_page_q;
    assign rom_page    = active_page_q;
    assign pixel_out   = pixel_q;

endmodule

// File: tb/tb_menu_page_renderer.sv
// Randomized self-checking bench for menu_page_renderer against a frame-level reference model.
module tb_menu_page_renderer;

    localparam int W  = 32;
    localparam int H  = 24;
    localparam int NP = 3;
    localparam int IH = 8;
    localparam int HT = W + 4;
    localparam int VT = H + 4;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [12:0] hcount = '0, vcount = '0;
    logic        page_req_valid = 1'b0;
    logic [1:0]  page_req_id = '0;
    logic        page_req_ready, page_ack, page_err;
    logic [1:0]  active_page, rom_page;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_addr = '0;
    logic [11:0] pal_data = '0;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_data = '0;
    logic [11:0] pixel_out;
`ifdef MENU_HIGHLIGHT_EN
    logic [7:0]  highlight_item = '0;
    logic        highlight_on = 1'b0;
`endif

    menu_page_renderer #(
        .WIDTH(W), .HEIGHT(H), .NUM_PAGES(NP), .BPP(2), .ROM_LATENCY(1), .ITEM_H(IH)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .hcount(hcount), .vcount(vcount),
        .page_req_valid(page_req_valid), .page_req_id(page_req_id),
        .page_req_ready(page_req_ready), .page_ack(page_ack), .page_err(page_err),
        .active_page(active_page), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`ifdef MENU_HIGHLIGHT_EN
        .highlight_item(highlight_item), .highlight_on(highlight_on),
`endif
        .rom_page(rom_page), .rom_addr(rom_addr), .rom_data(rom_data), .pixel_out(pixel_out)
    );

    always #5 clk_in = ~clk_in;

    // External ROM bank: one-cycle read latency, random contents or a forced constant.
    logic [1:0] rom_mem [NP*W*H];
    int rom_force = 1;
    always @(posedge clk_in)
        rom_data <= (rom_force >= 0) ? rom_force[1:0]
                    : rom_mem[(int'(rom_page) % NP) * W * H + int'(rom_addr) % (W * H)];

    // Reference model state
    int          errors = 0, checks = 0, stepn = 0;
    logic [11:0] m_pal [4];
    int          m_page, m_req, m_fs, m_err_at;
    bit          m_busy;
    logic [11:0] exp_q [$];

    task automatic model_reset();
        m_pal = '{12'h000, 12'hF00, 12'h00F, 12'h0F0};
        m_page = 0; m_req = 0; m_fs = -1; m_err_at = -1; m_busy = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_rom(input int v);
        rom_force = v;
        exp_q.delete();
    endtask

    // One pixel clock: check outputs for the previous edge, then drive the next coordinate.
    task automatic step(input int h, input int v, input bit rq = 0, input int rid = 0,
                        input bit we = 0, input int wa = 0, input int wd = 0);
        logic [11:0] e, val;
        bit          exp_ack, ib;
        int          idx;
        @(posedge clk_in); #1;
        stepn++;
        if (m_fs >= 0 && stepn == m_fs + 3) begin
            m_page = m_req; m_busy = 1'b0; m_fs = -1;
        end
        exp_ack = (m_fs >= 0) && (stepn == m_fs + 2);
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            checks++;
            if (pixel_out !== e) begin
                errors++; $display("FAIL pixel step=%0d got=%h exp=%h", stepn, pixel_out, e);
            end
        end
        checks++;
        if (page_ack !== exp_ack) begin
            errors++; $display("FAIL page_ack step=%0d got=%b exp=%b", stepn, page_ack, exp_ack);
        end
        checks++;
        if (page_err !== (stepn == m_err_at)) begin
            errors++; $display("FAIL page_err step=%0d got=%b exp=%b", stepn, page_err, stepn == m_err_at);
        end
        checks++;
        if (active_page !== 2'(m_page) || rom_page !== 2'(m_page)) begin
            errors++; $display("FAIL page step=%0d active=%0d rom_page=%0d exp=%0d", stepn, active_page, rom_page, m_page);
        end
        checks++;
        if (page_req_ready !== !m_busy) begin
            errors++; $display("FAIL ready step=%0d got=%b exp=%b", stepn, page_req_ready, !m_busy);
        end

        hcount = 13'(h); vcount = 13'(v);
        page_req_valid = rq; page_req_id = 2'(rid);
        pal_we = we; pal_addr = 2'(wa); pal_data = 12'(wd);

        if (rq && !m_busy) begin
            if (rid >= NP) m_err_at = stepn + 1;
            else begin m_busy = 1'b1; m_req = rid; end
        end
        if (we) m_pal[wa] = 12'(wd);
        if (m_busy && m_fs < 0 && h == 0 && v == 0) m_fs = stepn;

        ib = (h < W) && (v < H);
        val = 12'h000;
        if (ib) begin
            idx = (rom_force >= 0) ? rom_force : int'(rom_mem[m_page * W * H + h + v * W]);
            val = m_pal[idx];
`ifdef MENU_HIGHLIGHT_EN
            if (highlight_on && (v / IH) == int'(highlight_item)) val = ~val;
`endif
        end
        exp_q.push_back(val);
    endtask

    task automatic frame(input int rh = -1, input int rv = -1, input int rid = 0, input bit rnd_pal = 0);
        bit rq, we;
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                rq = (h == rh) && (v == rv);
                we = rnd_pal && ($urandom_range(0, 7) == 0);
                step(h, v, rq, rid, we, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            end
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        page_req_valid = 1'b0; pal_we = 1'b0;
        reset_in = 1'b0;
        #1;
        checks++;
        if (pixel_out !== 12'h000 || active_page !== 2'd0 || page_ack !== 1'b0 ||
            page_err !== 1'b0 || page_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state pix=%h page=%0d ack=%b err=%b rdy=%b exp 000/0/0/0/1",
                     pixel_out, active_page, page_ack, page_err, page_req_ready);
        end
        model_reset();
        repeat (2) @(posedge clk_in);
        #2 reset_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_scan_page0();
        set_rom(1);
        frame();
    endtask

    task automatic test_palette();
        set_rom(1);
        repeat (4) step(3, 2);
        step(3, 2, 0, 0, 1, 1, 12'hABC);
        repeat (4) step(3, 2);
        step(W, 2);
        step(3, H);
        repeat (3) step(5, 5);
    endtask

    task automatic test_random_rom();
        set_rom(-1);
        frame();
    endtask

    task automatic test_page_switch();
        set_rom(-1);
        frame(5, 10, 2);
        frame();
        frame();
    endtask

    task automatic test_page_err();
        frame(7, 3, 3);
    endtask

    task automatic test_back_to_back();
        frame(1, 0, 1);
        frame();
        frame(0, 0, 1);
        frame(4, 4, 0, 1);
    endtask

    task automatic test_reset_pending();
        set_rom(1);
        for (int v = 0; v < 5; v++)
            for (int h = 0; h < HT; h++) step(h, v, (h == 2 && v == 1), 1);
        do_reset();
        set_rom(1);
        frame();
    endtask

`ifdef MENU_HIGHLIGHT_EN
    task automatic test_highlight();
        highlight_item = 8'd1; highlight_on = 1'b1;
        set_rom(0);
        frame();
        highlight_on = 1'b0;
        set_rom(-1);
        frame();
    endtask
`endif

    initial begin
        for (int i = 0; i < NP * W * H; i++) rom_mem[i] = 2'($urandom_range(0, 3));
        model_reset();
        fork
            begin
                test_reset();
                test_scan_page0();
                test_palette();
                test_random_rom();
                test_page_switch();
                test_page_err();
                test_back_to_back();
                test_reset_pending();
`ifdef MENU_HIGHLIGHT_EN
                test_highlight();
`endif
            end
            begin
                #2000000;
                errors++;
                $display("FAIL timeout sim time exceeded budget");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
